// File: rtl/stack_ctrl_pkg.sv
// Shared FSM state encoding and default geometry for the stack controller.
package stack_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_SETUP = 3'd1,
      WR_PULSE = 3'd2,
      WR_HOLD  = 3'd3,
      RD_SEL   = 3'd4,
      RD_CAP   = 3'd5
   } state_t;

   localparam int N_DEF     = 8;
   localparam int DEPTH_DEF = 8;
   localparam int AW_DEF    = 3;

endpackage

// File: rtl/stack_row_dec.sv
// Combinational pointer-to-row one-hot decoder; all zero when disabled.
// Indices at or beyond DEPTH select nothing.
module stack_row_dec #(
   parameter int AW    = 3,
   parameter int DEPTH = 8
) (
   input  logic             en,
   input  logic [AW-1:0]    idx,
   output logic [DEPTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (en && (idx == i[AW-1:0])) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer for a latch-based stack array: write takes 3 cycles after accept, read 2 (+Valid in first idle cycle).
// Requests are sampled only when Busy=0; requests during a sequence are dropped without Err.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Push,
   input  logic             Pop,
   input  logic [N-1:0]     DataIn,
   output logic [N-1:0]     DataOut,
   output logic             Valid,
   output logic             Busy,
   output logic             Full,
   output logic             Empty,
   output logic [AW:0]      Count,
   output logic             Err,
   output logic [DEPTH-1:0] RowSel,
   output logic             WriteEn,
   output logic [N-1:0]     MemIn,
   input  logic [N-1:0]     MemOut
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   state_t state, state_nxt;

   logic             accept_push, accept_pop, reject;
   logic             dec_en;
   logic [AW-1:0]    dec_idx;
   logic [DEPTH-1:0] dec_out;

   logic [DEPTH-1:0] row_sel_nxt;
   logic             write_en_nxt, valid_nxt, err_nxt;
   logic [N-1:0]     mem_in_nxt, data_out_nxt;
   logic [AW:0]      count_nxt;

   // Count doubles as the stack pointer; it reaches DEPTH, which SP bits alone cannot express.
   assign reject      = (state == IDLE) && ((Push && Pop) || (Push && Full) || (Pop && Empty));
   assign accept_push = (state == IDLE) && Push && !Pop && !Full;
   assign accept_pop  = (state == IDLE) && Pop && !Push && !Empty;
   assign dec_en      = accept_push || accept_pop;
   assign dec_idx     = accept_push ? Count[AW-1:0] : (Count[AW-1:0] - IDX_ONE);

   stack_row_dec #(.AW(AW), .DEPTH(DEPTH)) u_row_dec (
      .en     (dec_en),
      .idx    (dec_idx),
      .onehot (dec_out)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept_push)     state_nxt = WR_SETUP;
            else if (accept_pop) state_nxt = RD_SEL;
         end
         WR_SETUP: state_nxt = WR_PULSE;
         WR_PULSE: state_nxt = WR_HOLD;
         WR_HOLD:  state_nxt = IDLE;
         RD_SEL:   state_nxt = RD_CAP;
         RD_CAP:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; RowSel/MemIn are held unless a transition changes them.
   always_comb begin
      row_sel_nxt  = RowSel;
      write_en_nxt = 1'b0;
      mem_in_nxt   = MemIn;
      data_out_nxt = DataOut;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;
      count_nxt    = Count;
      case (state)
         IDLE: begin
            err_nxt = reject;
            if (accept_push) begin
               mem_in_nxt  = DataIn;
               row_sel_nxt = dec_out;
            end else if (accept_pop) begin
               row_sel_nxt = dec_out;
            end
         end
         WR_SETUP: write_en_nxt = 1'b1;
         WR_HOLD: begin
            row_sel_nxt = '0;
            count_nxt   = Count + CNT_ONE;
         end
         RD_CAP: begin
            data_out_nxt = MemOut;
            valid_nxt    = 1'b1;
            row_sel_nxt  = '0;
            count_nxt    = Count - CNT_ONE;
         end
         default: ;
      endcase
   end

   // Asynchronous reset drops the array strobes immediately, even mid-sequence.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RowSel  <= '0;
         WriteEn <= 1'b0;
         MemIn   <= '0;
         DataOut <= '0;
         Valid   <= 1'b0;
         Err     <= 1'b0;
         Busy    <= 1'b0;
         Count   <= '0;
         Full    <= 1'b0;
         Empty   <= 1'b1;
      end else begin
         RowSel  <= row_sel_nxt;
         WriteEn <= write_en_nxt;
         MemIn   <= mem_in_nxt;
         DataOut <= data_out_nxt;
         Valid   <= valid_nxt;
         Err     <= err_nxt;
         Busy    <= (state_nxt != IDLE);
         Count   <= count_nxt;
         Full    <= (count_nxt == FULL_CNT);
         Empty   <= (count_nxt == '0);
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: latch-array model on the memory side, LIFO scoreboard on the user side.
module tb_stack_ctrl;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;
   logic       Push = 1'b0;
   logic       Pop = 1'b0;
   logic [7:0] DataIn = '0;
   logic [7:0] DataOut;
   logic       Valid, Busy, Full, Empty, Err, WriteEn;
   logic [3:0] Count;
   logic [7:0] RowSel;
   logic [7:0] MemIn;
   logic [7:0] MemOut;

   int passed = 0;
   int total  = 0;

   logic [7:0] mstk [$];
   logic [7:0] exp_q [$];
   logic [7:0] mem [8];
   logic       prev_valid = 1'b0;

   always #5 Clk = ~Clk;

   stack_ctrl #(.N(8), .DEPTH(8), .AW(3)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Push    (Push),
      .Pop     (Pop),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .Valid   (Valid),
      .Busy    (Busy),
      .Full    (Full),
      .Empty   (Empty),
      .Count   (Count),
      .Err     (Err),
      .RowSel  (RowSel),
      .WriteEn (WriteEn),
      .MemIn   (MemIn),
      .MemOut  (MemOut)
   );

   // Level-sensitive rows: transparent while WriteEn and their RowSel bit are high.
   always @(WriteEn or RowSel or MemIn) begin
      if (WriteEn)
         for (int i = 0; i < 8; i++)
            if (RowSel[i]) mem[i] = MemIn;
   end

   always_comb begin
      MemOut = '0;
      for (int i = 0; i < 8; i++)
         if (RowSel[i]) MemOut = MemOut | mem[i];
   end

   // Popped data is compared against the scoreboard whenever Valid pulses.
   always @(negedge Clk) begin
      if (Valid) begin
         total++;
         if (exp_q.size() == 0)
            $display("FAIL pop_data: Valid with data %h but no pop expected", DataOut);
         else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (DataOut !== e) $display("FAIL pop_data: got %h expected %h", DataOut, e);
            else passed++;
         end
         total++;
         if (prev_valid) $display("FAIL valid_width: Valid high %0d consecutive cycles, expected 1", 2);
         else passed++;
      end
      if (WriteEn) begin
         total++;
         if (!$onehot(RowSel)) $display("FAIL we_onehot: RowSel %b during WriteEn, expected one-hot", RowSel);
         else passed++;
      end
      prev_valid = Valid;
   end

   task automatic wait_idle();
      int n = 0;
      while (Busy && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (Busy) begin
         total++;
         $display("FAIL busy_timeout: Busy still %b after %0d cycles, expected 0", Busy, n);
      end
   endtask

   task automatic do_push(input logic [7:0] d);
      wait_idle();
      Push = 1'b1;
      DataIn = d;
      if (mstk.size() < 8) mstk.push_back(d);
      @(negedge Clk);
      Push = 1'b0;
      wait_idle();
   endtask

   task automatic do_pop();
      wait_idle();
      Pop = 1'b1;
      if (mstk.size() > 0) exp_q.push_back(mstk.pop_back());
      @(negedge Clk);
      Pop = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset();
      #1 Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", Empty); else passed++;
      total++; if (Count !== 4'd0) $display("FAIL rst_count: got %0d expected 0", Count); else passed++;
      total++; if (RowSel !== 8'h00) $display("FAIL rst_rowsel: got %h expected 00", RowSel); else passed++;
      total++; if (WriteEn !== 1'b0) $display("FAIL rst_we: got %b expected 0", WriteEn); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", Busy); else passed++;
      total++; if (Full !== 1'b0) $display("FAIL rst_full: got %b expected 0", Full); else passed++;
      Rst_n = 1'b1;
      @(negedge Clk);
      total++; if (Busy !== 1'b0 || Empty !== 1'b1) $display("FAIL idle_after_rst: Busy=%b Empty=%b expected 0/1", Busy, Empty); else passed++;
   endtask

   task automatic test_single_push();
      @(negedge Clk);
      Push = 1'b1;
      DataIn = 8'hA5;
      mstk.push_back(8'hA5);
      @(negedge Clk);
      Push = 1'b0;
      DataIn = 8'h00;
      for (int k = 0; k < 4; k++) begin
         logic [7:0] ers;
         logic       ewe;
         if (k > 0) @(negedge Clk);
         ers = (k < 3) ? 8'h01 : 8'h00;
         ewe = (k == 1);
         total++; if (RowSel !== ers) $display("FAIL push_rowsel[%0d]: got %h expected %h", k, RowSel, ers); else passed++;
         total++; if (WriteEn !== ewe) $display("FAIL push_we[%0d]: got %b expected %b", k, WriteEn, ewe); else passed++;
         if (k < 3) begin
            total++; if (MemIn !== 8'hA5) $display("FAIL push_memin[%0d]: got %h expected a5", k, MemIn); else passed++;
         end
      end
      total++; if (Count !== 4'd1) $display("FAIL push_count: got %0d expected 1", Count); else passed++;
      total++; if (Empty !== 1'b0) $display("FAIL push_empty: got %b expected 0", Empty); else passed++;
      do_pop();
   endtask

   task automatic test_lifo();
      do_push(8'h11);
      do_push(8'h22);
      do_push(8'h33);
      total++; if (Count !== 4'd3) $display("FAIL lifo_count: got %0d expected 3", Count); else passed++;
      repeat (3) do_pop();
      @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL lifo_empty: got %b expected 1", Empty); else passed++;
      total++; if (exp_q.size() != 0) $display("FAIL lifo_pending: %0d pops without Valid, expected 0", exp_q.size()); else passed++;
   endtask

   task automatic test_full_empty();
      int we_seen = 0;
      int val_seen = 0;
      for (int i = 0; i < 8; i++) do_push(8'(i * 16 + 3));
      total++; if (Full !== 1'b1) $display("FAIL fill_full: got %b expected 1", Full); else passed++;
      total++; if (Count !== 4'd8) $display("FAIL fill_count: got %0d expected 8", Count); else passed++;
      Push = 1'b1;
      DataIn = 8'hEE;
      @(negedge Clk);
      Push = 1'b0;
      total++; if (Err !== 1'b1) $display("FAIL full_err: got %b expected 1", Err); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL full_busy: got %b expected 0", Busy); else passed++;
      for (int k = 0; k < 4; k++) begin
         if (WriteEn) we_seen++;
         @(negedge Clk);
      end
      total++; if (Err !== 1'b0) $display("FAIL full_err_pulse: got %b expected 0", Err); else passed++;
      total++; if (we_seen != 0) $display("FAIL full_no_write: WriteEn seen %0d cycles expected 0", we_seen); else passed++;
      total++; if (Count !== 4'd8) $display("FAIL full_count: got %0d expected 8", Count); else passed++;
      repeat (8) do_pop();
      @(negedge Clk);
      total++; if (Empty !== 1'b1 || Count !== 4'd0) $display("FAIL drain: Empty=%b Count=%0d expected 1/0", Empty, Count); else passed++;
      Pop = 1'b1;
      @(negedge Clk);
      Pop = 1'b0;
      total++; if (Err !== 1'b1) $display("FAIL empty_err: got %b expected 1", Err); else passed++;
      for (int k = 0; k < 4; k++) begin
         if (Valid) val_seen++;
         @(negedge Clk);
      end
      total++; if (val_seen != 0) $display("FAIL empty_valid: Valid seen %0d cycles expected 0", val_seen); else passed++;
   endtask

   task automatic test_conflict_busy();
      do_push(8'h5A);
      do_push(8'hC3);
      Push = 1'b1;
      Pop = 1'b1;
      @(negedge Clk);
      Push = 1'b0;
      Pop = 1'b0;
      total++; if (Err !== 1'b1) $display("FAIL both_err: got %b expected 1", Err); else passed++;
      @(negedge Clk);
      total++; if (Count !== 4'd2 || Busy !== 1'b0) $display("FAIL both_noop: Count=%0d Busy=%b expected 2/0", Count, Busy); else passed++;
      // Pop accepted, then Pop and Push held during the read sequence.
      Pop = 1'b1;
      exp_q.push_back(mstk.pop_back());
      @(negedge Clk);
      Push = 1'b1;
      total++; if (Err !== 1'b0) $display("FAIL busy_err0: got %b expected 0", Err); else passed++;
      @(negedge Clk);
      Pop = 1'b0;
      Push = 1'b0;
      total++; if (Err !== 1'b0) $display("FAIL busy_err1: got %b expected 0", Err); else passed++;
      @(negedge Clk);
      total++; if (Valid !== 1'b1) $display("FAIL busy_valid: got %b expected 1", Valid); else passed++;
      total++; if (Err !== 1'b0) $display("FAIL busy_err2: got %b expected 0", Err); else passed++;
      repeat (3) @(negedge Clk);
      total++; if (Count !== 4'd1 || Busy !== 1'b0) $display("FAIL busy_ignored: Count=%0d Busy=%b expected 1/0", Count, Busy); else passed++;
      do_pop();
   endtask

   task automatic test_reset_mid_write();
      int n = 0;
      do_push(8'h77);
      Push = 1'b1;
      DataIn = 8'h99;
      @(negedge Clk);
      Push = 1'b0;
      while (!WriteEn && n < 10) begin
         @(negedge Clk);
         n++;
      end
      total++; if (WriteEn !== 1'b1) $display("FAIL mid_reach_pulse: WriteEn=%b expected 1", WriteEn); else passed++;
      Rst_n = 1'b0;
      #1;
      total++; if (WriteEn !== 1'b0) $display("FAIL mid_rst_we: got %b expected 0", WriteEn); else passed++;
      total++; if (RowSel !== 8'h00) $display("FAIL mid_rst_rowsel: got %h expected 00", RowSel); else passed++;
      mstk.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      total++; if (Count !== 4'd0 || Empty !== 1'b1) $display("FAIL mid_rst_state: Count=%0d Empty=%b expected 0/1", Count, Empty); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", Busy); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_push();
      test_lifo();
      test_full_empty();
      test_conflict_busy();
      test_reset_mid_write();
      repeat (2) @(negedge Clk);
      total++; if (exp_q.size() != 0) $display("FAIL final_pending: %0d expected pops never returned, expected 0", exp_q.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
